// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load handshake, abort, and optional
// self-reload; pulses underflow for one cycle when decremented past zero.
module countdown_timer #(
   parameter  int MAX_COUNT = 31,
   localparam int BIT_WIDTH = $clog2(MAX_COUNT + 1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [BIT_WIDTH-1:0] load_value,
   input  logic                 auto_reload,
   input  logic                 dec,
   input  logic                 abort,
   output logic                 busy,
   output logic [BIT_WIDTH-1:0] out,
   output logic                 underflow
);

   localparam logic [BIT_WIDTH-1:0] MAX_VAL = BIT_WIDTH'(MAX_COUNT);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q;
   logic [BIT_WIDTH-1:0] out_q;
   logic [BIT_WIDTH-1:0] reload_val_q;
   logic                 reload_en_q;
   logic                 underflow_q;
   logic                 busy_q;
   logic                 ready_q;
   logic [BIT_WIDTH-1:0] load_clamped_d;

   // Only reachable when MAX_COUNT+1 is not a power of two.
   function automatic logic [BIT_WIDTH-1:0] clamp(input logic [BIT_WIDTH-1:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

   assign load_clamped_d = clamp(load_value);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         out_q        <= '0;
         reload_val_q <= '0;
         reload_en_q  <= 1'b0;
         underflow_q  <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         underflow_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  out_q        <= load_clamped_d;
                  reload_val_q <= load_clamped_d;
                  reload_en_q  <= auto_reload;
                  state_q      <= RUN;
                  busy_q       <= 1'b1;
                  ready_q      <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
                  out_q   <= '0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else if (dec) begin
                  if (out_q != '0) begin
                     out_q <= out_q - 1'b1;
                  end else begin
                     // Zero is an underflow event, never a wrap to all-ones.
                     underflow_q <= 1'b1;
                     if (reload_en_q) begin
                        out_q <= reload_val_q;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign out        = out_q;
   assign busy       = busy_q;
   assign load_ready = ready_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (MAX_COUNT 31 and 20) share stimulus,
// each checked every cycle against a behavioural model plus literal expectations.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       load_valid;
   logic [4:0] load_value;
   logic       auto_reload;
   logic       dec;
   logic       abort;

   logic       ready_a, busy_a, uf_a;
   logic [4:0] out_a;
   logic       ready_b, busy_b, uf_b;
   logic [4:0] out_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   countdown_timer #(.MAX_COUNT(31)) dut_a (
      .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(ready_a),
      .load_value(load_value), .auto_reload(auto_reload), .dec(dec), .abort(abort),
      .busy(busy_a), .out(out_a), .underflow(uf_a)
   );

   countdown_timer #(.MAX_COUNT(20)) dut_b (
      .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(ready_b),
      .load_value(load_value), .auto_reload(auto_reload), .dec(dec), .abort(abort),
      .busy(busy_b), .out(out_b), .underflow(uf_b)
   );

   // Model: remaining count, whether a run is active, and the armed reload value.
   int m_max [2] = '{31, 20};
   int m_out [2] = '{0, 0};
   int m_rv  [2] = '{0, 0};
   bit m_run [2] = '{0, 0};
   bit m_re  [2] = '{0, 0};
   bit m_uf  [2] = '{0, 0};
   bit started = 1'b0;

   always @(posedge clk) begin
      started = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!rstn) begin
            m_out[k] = 0; m_rv[k] = 0; m_run[k] = 0; m_re[k] = 0; m_uf[k] = 0;
         end else begin
            m_uf[k] = 0;
            if (!m_run[k]) begin
               if (load_valid) begin
                  m_rv[k]  = (int'(load_value) > m_max[k]) ? m_max[k] : int'(load_value);
                  m_out[k] = m_rv[k];
                  m_re[k]  = auto_reload;
                  m_run[k] = 1;
               end
            end else if (abort) begin
               m_run[k] = 0;
               m_out[k] = 0;
            end else if (dec) begin
               if (m_out[k] > 0) m_out[k] = m_out[k] - 1;
               else begin
                  m_uf[k] = 1;
                  if (m_re[k]) m_out[k] = m_rv[k];
                  else m_run[k] = 0;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("mdl_out_a",   int'(out_a),   m_out[0]);
         chk("mdl_busy_a",  int'(busy_a),  int'(m_run[0]));
         chk("mdl_ready_a", int'(ready_a), int'(!m_run[0]));
         chk("mdl_uf_a",    int'(uf_a),    int'(m_uf[0]));
         chk("mdl_out_b",   int'(out_b),   m_out[1]);
         chk("mdl_busy_b",  int'(busy_b),  int'(m_run[1]));
         chk("mdl_ready_b", int'(ready_b), int'(!m_run[1]));
         chk("mdl_uf_b",    int'(uf_b),    int'(m_uf[1]));
      end
   end

   // Apply one cycle of inputs; returns at the following negedge.
   task automatic cyc(input logic lv, input int val, input logic ar, input logic d, input logic ab);
      load_valid  = lv;
      load_value  = 5'(val);
      auto_reload = ar;
      dec         = d;
      abort       = ab;
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int o, input int b, input int u, input int r);
      chk({name, "_out"},   int'(out_a),   o);
      chk({name, "_busy"},  int'(busy_a),  b);
      chk({name, "_uf"},    int'(uf_a),    u);
      chk({name, "_ready"}, int'(ready_a), r);
   endtask

   int seq_r [10] = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2};
   int uf_r  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

   initial begin
      rstn = 1'b0; load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
      dec = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      lit("reset", 0, 0, 0, 1);
      rstn = 1'b1;

      // Load 5, dec held high until non-reload underflow.
      cyc(1, 5, 0, 0, 0);
      lit("load5", 5, 1, 0, 0);
      for (int i = 4; i >= 0; i--) begin
         cyc(0, 0, 0, 1, 0);
         chk("down5_out", int'(out_a), i);
      end
      cyc(0, 0, 0, 1, 0);
      lit("uf5", 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
      lit("after_uf5", 0, 0, 0, 1);

      // Auto-reload from 3.
      cyc(1, 3, 1, 0, 0);
      chk("rl_out0", int'(out_a), seq_r[0]);
      for (int i = 1; i < 10; i++) begin
         cyc(0, 0, 0, 1, 0);
         chk("rl_out", int'(out_a), seq_r[i]);
         chk("rl_uf", int'(uf_a), uf_r[i]);
         chk("rl_busy", int'(busy_a), 1);
      end
      cyc(0, 0, 0, 0, 1);
      lit("rl_abort", 0, 0, 0, 1);

      // Load 4, two decs, rejected load in RUN, then abort+dec.
      cyc(1, 4, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      chk("ab_out2", int'(out_a), 2);
      cyc(1, 9, 0, 0, 0);
      lit("ab_noload", 2, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      lit("ab_abort", 0, 0, 0, 1);

      // Abort beats dec even at zero.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1);
      lit("ab_zero", 0, 0, 0, 1);

      // Clamp: 31 into MAX_COUNT=20.
      cyc(1, 31, 0, 0, 0);
      chk("clamp_a", int'(out_a), 31);
      chk("clamp_b", int'(out_b), 20);
      cyc(0, 0, 0, 0, 1);

      // Load 0, one dec underflows.
      cyc(1, 0, 0, 0, 0);
      chk("zero_busy_b", int'(busy_b), 1);
      chk("zero_out_b", int'(out_b), 0);
      cyc(0, 0, 0, 1, 0);
      chk("zero_uf_b", int'(uf_b), 1);
      chk("zero_ready_b", int'(ready_b), 1);
      chk("zero_busy_b2", int'(busy_b), 0);

      // dec/abort ignored in IDLE.
      cyc(0, 0, 0, 1, 1);
      lit("idle_ign", 0, 0, 0, 1);

      // Reset mid-run.
      cyc(1, 7, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      chk("rst_pre", int'(out_a), 3);
      rstn = 1'b0;
      cyc(0, 0, 0, 1, 0);
      lit("rst_mid", 0, 0, 0, 1);
      rstn = 1'b1;

      // Reset suppresses a pending underflow.
      cyc(1, 0, 0, 0, 0);
      rstn = 1'b0;
      cyc(0, 0, 0, 1, 0);
      lit("rst_uf", 0, 0, 0, 1);
      rstn = 1'b1;

      // dec toggling from 2.
      cyc(1, 2, 0, 0, 0);
      cyc(0, 0, 0, 1, 0); chk("tog1", int'(out_a), 1);
      cyc(0, 0, 0, 0, 0); chk("tog2", int'(out_a), 1);
      cyc(0, 0, 0, 1, 0); chk("tog3", int'(out_a), 0);
      cyc(0, 0, 0, 0, 0); lit("tog4", 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("tog_uf", 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that decrements on `dec` and flags `underflow` when decremented past zero, optionally reloading itself. It counts in the opposite direction to the up-counter in `HW/comp/util`. It sits beside that counter to track remaining work, for example tiles or tokens left in a transfer, and uses the same `MAX_COUNT` sizing convention. Loads use a valid/ready handshake, so an upstream controller can arm it only when it is idle.

## Interface
Parameters:
- `MAX_COUNT`, default 31: largest loadable count.
- `BIT_WIDTH`, localparam `$clog2(MAX_COUNT + 1)`: width of the count.

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock.
- `rstn`  in  1  reset, synchronous and active-low.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  block accepts a load; high only in IDLE.
- `load_value`  in  BIT_WIDTH  start count; values above `MAX_COUNT` are clamped to `MAX_COUNT`.
- `auto_reload`  in  1  reload mode flag, sampled only on load acceptance.
- `dec`  in  1  decrement request; meaningful in RUN only.
- `abort`  in  1  cancel the current run.
- `busy`  out  1  high in RUN.
- `out`  out  BIT_WIDTH  current count, registered.
- `underflow`  out  1  registered single-cycle pulse.

## Operation
- State machine: IDLE (encoding 0) and RUN (encoding 1).
- Internal registers:
  - `reload_val` (BIT_WIDTH), the clamped load value.
  - `reload_en` (1), the sampled `auto_reload`.
- Reset (rstn=0 at a clock edge):
  - state=IDLE, out=0, underflow=0, busy=0, load_ready=1.
  - reload_val=0, reload_en=0.
- IDLE:
  - `dec` and `abort` are ignored.
  - When load_valid is high (load_ready is high here): out<=clamp(load_value), reload_val<=clamp(load_value), reload_en<=auto_reload, state<=RUN.
- RUN (load_valid is ignored, load_ready=0). Priority is abort > dec.
  - abort=1: state<=IDLE, out<=0, no underflow pulse.
  - dec=1 and out>0: out<=out-1.
  - dec=1, out==0, reload_en=1: out<=reload_val, underflow<=1, stay in RUN.
  - dec=1, out==0, reload_en=0: underflow<=1, state<=IDLE, out stays 0.
  - dec=0: hold.
- underflow is 0 in every cycle that does not follow one of the underflow edges above.
- Load value 0 is legal: the block enters RUN with out=0, and the first dec underflows.
- Arithmetic: unsigned; out never wraps below 0 (the zero case is handled as underflow, not as a 2^BIT_WIDTH-1 wrap).
- Clamp: `load_value > MAX_COUNT` loads `MAX_COUNT`. This only matters when MAX_COUNT+1 is not a power of two.

## Timing
- Load handshake: the transfer happens on the edge where load_valid && load_ready. out, busy=1 and load_ready=0 are visible in the next cycle.
- Decrement latency: 1 cycle; out updates on the edge that samples dec.
- underflow: high for exactly one cycle, the cycle after the edge that sampled dec with out==0.
  - Non-reload: busy=0 and load_ready=1 in that same cycle, so a new load can be accepted on the next edge.
  - Reload: out=reload_val in that same cycle.
- Back-to-back dec every cycle from load value N (reload_en=0): underflow occurs in cycle N+1 after the first dec edge. The first sampled dec is edge 0.
- Simultaneous abort and dec in RUN: abort wins; underflow stays 0 even if out==0.
- Reset mid-RUN: the next cycle shows the reset values; any pending underflow is suppressed.
- rstn has priority over every other input.

## Test plan
- Reset, then load_value=5, auto_reload=0, dec held high:
  - out goes 5,4,3,2,1,0.
  - On the next dec, underflow pulses once, busy falls and load_ready rises in that cycle.
  - out stays 0.
- MAX_COUNT=31, load 3 with auto_reload=1, dec continuous for 10 cycles:
  - out goes 3,2,1,0,3,2,1,0,3,2.
  - underflow pulses after each 0, with busy held at 1.
- Load 4, run dec twice, then assert abort and dec together:
  - Next cycle: out=0, busy=0, underflow=0.
  - A load_valid in RUN before the abort is not accepted (load_ready=0).
- MAX_COUNT=20, load_value=31 → out=20.
- MAX_COUNT=20, load_value=0, then one dec → underflow pulse, return to IDLE.
- Load 7, dec to 3, pull rstn low for one edge with dec=1 → out=0, busy=0, underflow=0, load_ready=1 the next cycle.
- dec toggling 1,0,1,0 from load 2 → out holds in the dec=0 cycles and reaches 0 after two dec edges; no underflow until a third dec.
